icache_nway: RTL and testbench
==============================

ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 Parameter WAYS, default 4: associativity; power of two, 2..8.
REQ-002 Parameter SETS, default 16: sets per way; power of two, 2..64.
REQ-003 Parameter LINE_BITS, default 256: line width in bits; power of two, 64..512.
REQ-004 Parameter CNT_W, default 32: width of each performance counter.
REQ-005 Derived widths: OFF = log2(LINE_BITS/8); IDX = log2(SETS); TAG = 32-OFF-IDX.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 ufp_addr  in  32  request byte address; held stable by requester until ufp_resp.
REQ-009 ufp_rmask  in  4  read request; nonzero means a request is present.
REQ-010 ufp_rdata  out  LINE_BITS  line containing ufp_addr; valid only while ufp_resp=1.
REQ-011 ufp_resp  out  1  one-cycle response strobe.
REQ-012 dfp_addr  out  32  line-aligned fill address (low OFF bits zero).
REQ-013 dfp_read  out  1  fill request; held high until dfp_resp.
REQ-014 dfp_rdata  in  LINE_BITS  fill data; sampled when dfp_resp=1.
REQ-015 dfp_resp  in  1  fill completion strobe.
REQ-016 flush  in  1  single-cycle pulse requesting invalidation of every line.
REQ-017 flush_busy  out  1  high while a flush is pending or executing.
REQ-018 hit_count  out  CNT_W  saturating count of hits.
REQ-019 miss_count  out  CNT_W  saturating count of misses.

Function
REQ-020 Tag, data and valid storage SHALL be flip-flop arrays indexed by ufp_addr[OFF+IDX-1:OFF]; the tag is ufp_addr[31:OFF+IDX].
REQ-021 The FSM SHALL have exactly four states: IDLE, LOOKUP, FILL and FLUSH.
REQ-022 A one-entry line buffer (tag 32-OFF bits, data, valid bit) SHALL hold the most recently returned line.
REQ-023 IDLE, request present, line-buffer valid and address match: ufp_resp=1 in the same cycle with buffer data; hit_count+1; state stays IDLE.
REQ-024 IDLE, request present, no line-buffer match: register the address; next state LOOKUP; no response.
REQ-025 LOOKUP hit (tag equal, valid set; at most one way matches): ufp_resp=1 with that way's line; update PLRU; load line buffer; hit_count+1; next state IDLE.
REQ-026 LOOKUP miss: victim is the lowest-index invalid way if any exists, otherwise the tree-PLRU victim; miss_count+1; next state FILL.
REQ-027 FILL: dfp_read=1 and dfp_addr={registered addr[31:OFF], OFF zeros}, both held constant until dfp_resp.
REQ-028 FILL with dfp_resp=1 in one cycle: write data, tag and valid=1 to the victim way; update PLRU; load line buffer; ufp_resp=1 with ufp_rdata=dfp_rdata; next state IDLE.
REQ-029 Miss latency: ufp_resp SHALL assert in the same cycle as dfp_resp.
REQ-030 PLRU SHALL be a WAYS-1 bit tree per set; an access points every node on its path away from the accessed way; the victim is found by following the node bits.
REQ-031 Flush in IDLE SHALL take priority over a coincident request and move to FLUSH.
REQ-032 Flush arriving in LOOKUP or FILL SHALL be latched as pending and let the current access complete; enter FLUSH on the next IDLE cycle.
REQ-033 FLUSH, one cycle: clear all valid bits, all PLRU bits and line-buffer valid; ufp_resp=0; next state IDLE.
REQ-034 flush_busy=1 from the cycle after flush is sampled through the FLUSH cycle inclusive.
REQ-035 Counters SHALL saturate at all-ones and never wrap.
REQ-036 When no response is given, ufp_rdata SHALL be 0.
REQ-037 dfp_addr SHALL be 0 and dfp_read SHALL be 0 outside FILL.

Reset
REQ-038 rst_n low SHALL immediately force: state IDLE, all valid and PLRU bits 0, line buffer invalid, pending flush 0, counters 0, and every output 0.
REQ-039 Reset asserted during FILL SHALL abandon the fill; a dfp_resp arriving after reset release SHALL be ignored.
REQ-040 Tag and data array contents need not be reset.

Verification (WAYS=4, SETS=16, LINE_BITS=256)
REQ-041 Cold read 0x0000_1040, dfp_resp after 5 cycles -> dfp_addr=0x0000_1040, ufp_resp in the dfp_resp cycle, miss_count=1.
REQ-042 Repeat read 0x0000_1044 -> ufp_resp in the same cycle from the line buffer, hit_count=1, no dfp_read.
REQ-043 Fill 5 lines mapping to set 2, then re-read the first line -> the fifth fill evicts the PLRU way (way 0 after in-order fills), and the re-read misses.
REQ-044 Flush pulse during FILL -> the fill completes, then flush_busy stays high through FLUSH, and the next read of the same address misses.
REQ-045 rst_n low mid-FILL -> outputs 0 immediately, and after release a read of the same address misses again.
REQ-046 Preload hit_count to all-ones (CNT_W=4 build), then one more hit -> the count holds at 0xF.

Source files
------------

// File: rtl/icache_nway_if.sv
// Request/fill bus of the N-way instruction cache: upstream fetch port plus downstream line-fill port.
interface icache_nway_if #(
  parameter int LINE_BITS = 256
);
  logic [31:0]          ufp_addr;
  logic [3:0]           ufp_rmask;
  logic [LINE_BITS-1:0] ufp_rdata;
  logic                 ufp_resp;
  logic [31:0]          dfp_addr;
  logic                 dfp_read;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;

  modport slave (
    input  ufp_addr, ufp_rmask, dfp_rdata, dfp_resp,
    output ufp_rdata, ufp_resp, dfp_addr, dfp_read
  );

  modport master (
    output ufp_addr, ufp_rmask, dfp_rdata, dfp_resp,
    input  ufp_rdata, ufp_resp, dfp_addr, dfp_read
  );
endinterface

// File: rtl/icache_nway.sv
// Set-associative read-only instruction cache with tree-PLRU replacement,
// a one-entry line buffer, whole-cache flush and saturating hit/miss counters.
module icache_nway #(
  parameter int WAYS      = 4,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  icache_nway_if.slave     bus,
  input  logic             flush,
  output logic             flush_busy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int OFF = $clog2(LINE_BITS / 8);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - OFF - IDX;
  localparam int LVL = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, FILL = 2'd2, FLUSH = 2'd3} state_t;

  state_t                state_r, state_n;
  logic [TAG-1:0]        tag_r  [WAYS][SETS];
  logic [LINE_BITS-1:0]  data_r [WAYS][SETS];
  logic [WAYS-1:0]       valid_r [SETS];
  logic [WAYS-2:0]       plru_r  [SETS];
  logic [31-OFF:0]       line_r;
  logic [LVL-1:0]        victim_r;
  logic [31-OFF:0]       lb_tag_r;
  logic [LINE_BITS-1:0]  lb_data_r;
  logic                  lb_valid_r;
  logic                  flush_pend_r;
  logic [CNT_W-1:0]      hit_count_r, miss_count_r;

  logic [IDX-1:0]        idx_s;
  logic [TAG-1:0]        tag_s;
  logic                  match_s, hit_s, free_s;
  logic [LVL-1:0]        hit_way_s, free_way_s, victim_s, plru_way_s;
  logic                  resp_s, dfp_read_s, capture_s, miss_s, hit_inc_s;
  logic                  lb_load_s, plru_upd_s, fill_wr_s, flush_do_s;
  logic [LINE_BITS-1:0]  rdata_s, lb_data_s;
  logic [31:0]           dfp_addr_s;

  // An access points every node on its path away from the accessed way.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits, input logic [LVL-1:0] way);
    logic [WAYS-2:0] t;
    int n;
    t = bits;
    n = 0;
    for (int l = LVL - 1; l >= 0; l--) begin
      t[n] = ~way[l];
      n    = 2 * n + 1 + int'(way[l]);
    end
    return t;
  endfunction

  function automatic logic [LVL-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [LVL-1:0] v;
    logic b;
    int n;
    v = '0;
    n = 0;
    for (int l = LVL - 1; l >= 0; l--) begin
      b    = bits[n];
      v[l] = b;
      n    = 2 * n + 1 + int'(b);
    end
    return v;
  endfunction

  assign idx_s    = line_r[IDX-1:0];
  assign tag_s    = line_r[31-OFF:IDX];
  assign victim_s = free_s ? free_way_s : plru_victim(plru_r[idx_s]);

  // Way match and lowest-index invalid way for the registered request.
  always_comb begin
    match_s    = 1'b0;
    hit_s      = 1'b0;
    hit_way_s  = '0;
    free_s     = 1'b0;
    free_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_s    = valid_r[idx_s][w] && (tag_r[w][idx_s] == tag_s);
      hit_s      = hit_s | match_s;
      hit_way_s  = match_s ? LVL'(w) : hit_way_s;
      free_s     = free_s | ~valid_r[idx_s][w];
      free_way_s = valid_r[idx_s][w] ? free_way_s : LVL'(w);
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_n    = state_r;
    resp_s     = 1'b0;
    rdata_s    = '0;
    dfp_read_s = 1'b0;
    dfp_addr_s = 32'd0;
    capture_s  = 1'b0;
    miss_s     = 1'b0;
    hit_inc_s  = 1'b0;
    lb_load_s  = 1'b0;
    lb_data_s  = '0;
    plru_upd_s = 1'b0;
    plru_way_s = '0;
    fill_wr_s  = 1'b0;
    flush_do_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush || flush_pend_r) begin
          state_n = FLUSH;
        end else if (bus.ufp_rmask != 4'd0) begin
          if (lb_valid_r && (lb_tag_r == bus.ufp_addr[31:OFF])) begin
            resp_s    = 1'b1;
            rdata_s   = lb_data_r;
            hit_inc_s = 1'b1;
          end else begin
            capture_s = 1'b1;
            state_n   = LOOKUP;
          end
        end else begin
          state_n = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          resp_s     = 1'b1;
          rdata_s    = data_r[hit_way_s][idx_s];
          plru_upd_s = 1'b1;
          plru_way_s = hit_way_s;
          lb_load_s  = 1'b1;
          lb_data_s  = data_r[hit_way_s][idx_s];
          hit_inc_s  = 1'b1;
          state_n    = IDLE;
        end else begin
          miss_s  = 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        dfp_read_s = 1'b1;
        dfp_addr_s = {line_r, {OFF{1'b0}}};
        if (bus.dfp_resp) begin
          fill_wr_s  = 1'b1;
          plru_upd_s = 1'b1;
          plru_way_s = victim_r;
          lb_load_s  = 1'b1;
          lb_data_s  = bus.dfp_rdata;
          resp_s     = 1'b1;
          rdata_s    = bus.dfp_rdata;
          state_n    = IDLE;
        end else begin
          state_n = FILL;
        end
      end
      FLUSH: begin
        flush_do_s = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_n;
  end

  // Control state: request line, victim, line buffer, valid/PLRU, pending flush, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_r       <= '0;
      victim_r     <= '0;
      lb_tag_r     <= '0;
      lb_data_r    <= '0;
      lb_valid_r   <= 1'b0;
      flush_pend_r <= 1'b0;
      hit_count_r  <= '0;
      miss_count_r <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else begin
      if (capture_s) line_r <= bus.ufp_addr[31:OFF];
      if (miss_s) victim_r <= victim_s;
      if (lb_load_s) begin
        lb_tag_r   <= line_r;
        lb_data_r  <= lb_data_s;
        lb_valid_r <= 1'b1;
      end
      if (fill_wr_s) valid_r[idx_s][victim_r] <= 1'b1;
      if (plru_upd_s) plru_r[idx_s] <= plru_touch(plru_r[idx_s], plru_way_s);
      // A flush seen mid-access waits here until the FSM is back in IDLE.
      flush_pend_r <= (state_r == IDLE) ? 1'b0 : (flush_pend_r | flush);
      if (hit_inc_s && (hit_count_r != {CNT_W{1'b1}})) hit_count_r <= hit_count_r + CNT_W'(1);
      if (miss_s && (miss_count_r != {CNT_W{1'b1}})) miss_count_r <= miss_count_r + CNT_W'(1);
      if (flush_do_s) begin
        lb_valid_r <= 1'b0;
        for (int s = 0; s < SETS; s++) begin
          valid_r[s] <= '0;
          plru_r[s]  <= '0;
        end
      end
    end
  end

  // Tag and data arrays hold no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_wr_s) begin
      tag_r[victim_r][idx_s]  <= tag_s;
      data_r[victim_r][idx_s] <= bus.dfp_rdata;
    end
  end

  assign bus.ufp_resp  = resp_s;
  assign bus.ufp_rdata = rdata_s;
  assign bus.dfp_read  = dfp_read_s;
  assign bus.dfp_addr  = dfp_addr_s;
  assign flush_busy    = flush_pend_r | (state_r == FLUSH);
  assign hit_count     = hit_count_r;
  assign miss_count    = miss_count_r;
endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway: directed vector table, flush/reset sequences,
// randomized reads against a set-associative reference model, and a narrow-counter build.
module tb_icache_nway;
  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int LB   = 256;
  localparam int OFF  = 5;
  localparam int IDX  = 4;
  localparam int LVL  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush, flush2;
  logic        flush_busy, flush_busy2;
  logic [31:0] hit_count, miss_count;
  logic [3:0]  hit_count2, miss_count2;

  icache_nway_if #(.LINE_BITS(LB)) bus ();
  icache_nway_if #(.LINE_BITS(LB)) bus2 ();

  icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LB), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .flush_busy(flush_busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LB), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .flush(flush2),
    .flush_busy(flush_busy2), .hit_count(hit_count2), .miss_count(miss_count2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Backing memory contents: a fixed pattern derived from the line address.
  function automatic logic [LB-1:0] mem_line(input logic [31:0] a);
    logic [LB-1:0] r;
    logic [31:0] la;
    la = {a[31:OFF], 5'd0};
    for (int k = 0; k < LB / 32; k++) r[k*32 +: 32] = la ^ (32'h9E37_79B9 * 32'(k + 1)) ^ 32'h5A5A_0000;
    return r;
  endfunction

  // Reference model: per-set ways with tree-PLRU node bits, plus the line buffer.
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  int          m_plru  [SETS][WAYS-1];
  bit          m_lb_v;
  logic [31:0] m_lb_line;
  int          m_hits, m_misses;

  function automatic void m_touch(input int s, input int w);
    int node = 0;
    for (int l = 0; l < LVL; l++) begin
      int b = (w >> (LVL - 1 - l)) & 1;
      m_plru[s][node] = 1 - b;
      node = 2 * node + 1 + b;
    end
  endfunction

  function automatic int m_tree_victim(input int s);
    int node = 0;
    int v = 0;
    for (int l = 0; l < LVL; l++) begin
      int b = m_plru[s][node];
      v = 2 * v + b;
      node = 2 * node + 1 + b;
    end
    return v;
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 0;
    end
    m_lb_v = 1'b0;
  endfunction

  // Returns 0 = line-buffer hit, 1 = array hit, 2 = miss.
  function automatic int m_access(input logic [31:0] a);
    logic [31:0] line = a >> OFF;
    logic [31:0] tg = a >> (OFF + IDX);
    int s = int'(line % SETS);
    int v = -1;
    if (m_lb_v && m_lb_line == line) begin
      m_hits++;
      return 0;
    end
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == tg) begin
        m_touch(s, w);
        m_lb_v = 1'b1;
        m_lb_line = line;
        m_hits++;
        return 1;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) v = m_tree_victim(s);
    m_valid[s][v] = 1'b1;
    m_tag[s][v] = tg;
    m_touch(s, v);
    m_lb_v = 1'b1;
    m_lb_line = line;
    m_misses++;
    return 2;
  endfunction

  // One read: returns the response cycle (0 = request cycle, -1 = timed out).
  task automatic do_read(input logic [31:0] a, input int dly, output int lat,
                         output logic [LB-1:0] data, output bit saw_dfp, output logic [31:0] dfa);
    int fc = 0;
    lat = -1; saw_dfp = 1'b0; dfa = 32'd0; data = '0;
    @(negedge clk);
    bus.ufp_addr = a;
    bus.ufp_rmask = 4'hF;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.dfp_read) begin
        if (!saw_dfp) dfa = bus.dfp_addr;
        saw_dfp = 1'b1;
        if (fc == dly) begin
          bus.dfp_resp = 1'b1;
          bus.dfp_rdata = mem_line(bus.dfp_addr);
          #1;
        end
        fc++;
      end
      if (bus.ufp_resp) begin
        lat = c;
        data = bus.ufp_rdata;
        break;
      end
      @(negedge clk);
      bus.dfp_resp = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.ufp_rmask = 4'h0;
    bus.dfp_resp = 1'b0;
  endtask

  task automatic run_check(input logic [31:0] a, input int dly, input string nm);
    int k, lat, exp_lat;
    logic [LB-1:0] d;
    bit sd;
    logic [31:0] dfa;
    k = m_access(a);
    exp_lat = (k == 0) ? 0 : (k == 1) ? 1 : 2 + dly;
    do_read(a, dly, lat, d, sd, dfa);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_dfp_read_seen"}, sd, (k == 2));
    if (k == 2) chk({nm, "_dfp_addr"}, dfa, {a[31:OFF], 5'd0});
    chk({nm, "_rdata"}, d, mem_line(a));
    chk({nm, "_hit_count"}, hit_count, m_hits);
    chk({nm, "_miss_count"}, miss_count, m_misses);
  endtask

  task automatic flush_idle(input logic [31:0] a);
    @(negedge clk);
    flush = 1'b1;
    bus.ufp_addr = a;
    bus.ufp_rmask = 4'hF;
    #1;
    chk("flush_priority_resp", bus.ufp_resp, 1'b0);
    chk("flush_busy_sample_cycle", flush_busy, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    bus.ufp_rmask = 4'h0;
    #1;
    chk("flush_busy_in_flush", flush_busy, 1'b1);
    chk("flush_cycle_resp", bus.ufp_resp, 1'b0);
    @(negedge clk);
    #1;
    chk("flush_busy_after", flush_busy, 1'b0);
    m_flush();
  endtask

  typedef struct {
    logic [31:0] addr;
    int          dly;
    int          lat;
    bit          dfp;
    int          hits;
    int          misses;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, lat;
    logic [LB-1:0] d;
    bit sd;
    logic [31:0] dfa, a;

    tbl[0] = '{32'h0000_1040, 5, 7, 1'b1, 0, 1};
    tbl[1] = '{32'h0000_1044, 0, 0, 1'b0, 1, 1};
    tbl[2] = '{32'h0000_1240, 1, 3, 1'b1, 1, 2};
    tbl[3] = '{32'h0000_1440, 2, 4, 1'b1, 1, 3};
    tbl[4] = '{32'h0000_1640, 0, 2, 1'b1, 1, 4};
    tbl[5] = '{32'h0000_1840, 3, 5, 1'b1, 1, 5};
    tbl[6] = '{32'h0000_1040, 0, 2, 1'b1, 1, 6};
    tbl[7] = '{32'h0000_1240, 0, 1, 1'b0, 2, 6};
    tbl[8] = '{32'h0000_1440, 1, 3, 1'b1, 2, 7};

    rst_n = 1'b0; flush = 1'b0; flush2 = 1'b0;
    bus.ufp_addr = 32'd0; bus.ufp_rmask = 4'h0; bus.dfp_rdata = '0; bus.dfp_resp = 1'b0;
    bus2.ufp_addr = 32'd0; bus2.ufp_rmask = 4'h0; bus2.dfp_rdata = '0; bus2.dfp_resp = 1'b0;
    m_flush(); m_hits = 0; m_misses = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ufp_resp", bus.ufp_resp, 1'b0);
    chk("reset_ufp_rdata", bus.ufp_rdata, '0);
    chk("reset_dfp_read", bus.dfp_read, 1'b0);
    chk("reset_dfp_addr", bus.dfp_addr, 32'd0);
    chk("reset_flush_busy", flush_busy, 1'b0);
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Narrow-counter build: one miss, then a lookup-free line-buffer hit every cycle.
    @(negedge clk);
    bus2.ufp_addr = 32'h0000_0040; bus2.ufp_rmask = 4'hF;
    bus2.dfp_resp = 1'b1; bus2.dfp_rdata = mem_line(32'h0000_0040);
    repeat (10) @(negedge clk);
    #1;
    chk("sat_hit_count_counting", hit_count2, 4'd7);
    repeat (15) @(negedge clk);
    #1;
    chk("sat_hit_count_held", hit_count2, 4'hF);
    chk("sat_miss_count", miss_count2, 4'd1);
    bus2.ufp_rmask = 4'h0; bus2.dfp_resp = 1'b0;

    // Directed table: cold miss, line-buffer hit, set-2 fills and PLRU eviction.
    for (int i = 0; i < 9; i++) begin
      k = m_access(tbl[i].addr);
      do_read(tbl[i].addr, tbl[i].dly, lat, d, sd, dfa);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_dfp_read_seen", i), sd, tbl[i].dfp);
      if (tbl[i].dfp) chk($sformatf("tbl%0d_dfp_addr", i), dfa, {tbl[i].addr[31:OFF], 5'd0});
      chk($sformatf("tbl%0d_rdata", i), d, mem_line(tbl[i].addr));
      chk($sformatf("tbl%0d_hit_count", i), hit_count, tbl[i].hits);
      chk($sformatf("tbl%0d_miss_count", i), miss_count, tbl[i].misses);
    end

    // Flush pulse during FILL: the fill completes, then the cache is flushed.
    k = m_access(32'h0000_2000);
    @(negedge clk);
    bus.ufp_addr = 32'h0000_2000; bus.ufp_rmask = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("fflush_dfp_read", bus.dfp_read, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fflush_busy_pending", flush_busy, 1'b1);
    chk("fflush_dfp_read_held", bus.dfp_read, 1'b1);
    chk("fflush_dfp_addr_held", bus.dfp_addr, 32'h0000_2000);
    bus.dfp_resp = 1'b1; bus.dfp_rdata = mem_line(32'h0000_2000);
    #1;
    chk("fflush_fill_resp", bus.ufp_resp, 1'b1);
    chk("fflush_fill_rdata", bus.ufp_rdata, mem_line(32'h0000_2000));
    @(posedge clk);
    #1;
    bus.ufp_rmask = 4'h0; bus.dfp_resp = 1'b0;
    @(negedge clk);
    #1;
    chk("fflush_busy_idle", flush_busy, 1'b1);
    @(negedge clk);
    #1;
    chk("fflush_busy_flush", flush_busy, 1'b1);
    chk("fflush_no_resp", bus.ufp_resp, 1'b0);
    @(negedge clk);
    #1;
    chk("fflush_busy_clear", flush_busy, 1'b0);
    chk("fflush_miss_count", miss_count, m_misses);
    m_flush();
    run_check(32'h0000_2000, 2, "after_flush_same");
    run_check(32'h0000_1240, 0, "after_flush_old");

    // Reset in the middle of a fill; a late dfp_resp must be ignored.
    @(negedge clk);
    bus.ufp_addr = 32'h0000_3000; bus.ufp_rmask = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("rfill_dfp_read", bus.dfp_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rfill_dfp_read_low", bus.dfp_read, 1'b0);
    chk("rfill_dfp_addr_zero", bus.dfp_addr, 32'd0);
    chk("rfill_resp_low", bus.ufp_resp, 1'b0);
    chk("rfill_rdata_zero", bus.ufp_rdata, '0);
    chk("rfill_hit_zero", hit_count, 32'd0);
    chk("rfill_miss_zero", miss_count, 32'd0);
    chk("rfill_busy_zero", flush_busy, 1'b0);
    bus.ufp_rmask = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.dfp_resp = 1'b1; bus.dfp_rdata = mem_line(32'h0000_3000);
    #1;
    chk("rfill_late_resp_ignored", bus.ufp_resp, 1'b0);
    @(posedge clk);
    #1;
    bus.dfp_resp = 1'b0;
    m_flush(); m_hits = 0; m_misses = 0;
    run_check(32'h0000_3000, 1, "rfill_reread");
    run_check(32'h0000_1040, 0, "rfill_old_line");

    // Randomized reads over a small address pool so sets fill and evict.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        flush_idle(m_lb_line << OFF);
      end else begin
        a = ((32'($urandom_range(0, 5)) * 32'h0040_0001) << (OFF + IDX))
          | (32'($urandom_range(0, 3)) << OFF) | 32'($urandom_range(0, 31));
        run_check(a, $urandom_range(0, 3), $sformatf("rnd%0d", i));
      end
    end
    flush_idle(m_lb_line << OFF);
    run_check(32'h0000_1040, 1, "final_after_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
